// File: rtl/lut_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_cfg_pkg
// Brief    : Shared types and constants for the runtime-loadable LUT neuron.
// Revision : 1.0 - initial release
// ============================================================================
package lut_cfg_pkg;

  // Defaults match the fixed LogicNet neurons this block replaces.
  localparam int DEFAULT_IN_BITS  = 6;
  localparam int DEFAULT_OUT_BITS = 2;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Number of truth-table entries for a given lookup address width.
  function automatic int depth_of(input int bits);
    return 1 << bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_table_ram.sv
`default_nettype none
// ============================================================================
// Module   : lut_table_ram
// Brief    : DEPTH x DATA_BITS distributed RAM, one synchronous write port and
//            one registered read port with an enable (output holds when idle).
// Revision : 1.0 - initial release
// ============================================================================
module lut_table_ram
  import lut_cfg_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_IN_BITS,
  parameter int DATA_BITS = DEFAULT_OUT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_BITS);

  // Table storage is deliberately not reset; it is only meaningful once loaded.
  (* ram_style = "distributed" *)
  logic [DATA_BITS-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; the output register is reset and holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lut_neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_neuron_cfg_loader
// Brief    : Runtime-programmable LUT neuron. A config stream fills the truth
//            table one entry per beat; once loaded, lookups return the entry
//            one cycle later. Lookups outside RUN are dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module lut_neuron_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = DEFAULT_IN_BITS,
  parameter int OUT_BITS = DEFAULT_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                loaded,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                in_drop
);

  state_t               state;
  state_t               state_next;
  logic [IN_BITS-1:0]   wr_addr;
  logic [IN_BITS-1:0]   wr_addr_next;
  logic                 cfg_write;
  logic                 last_write;
  logic                 lookup_ok;
  logic                 lookup_drop;

  // Ready is a pure state decode so upstream sees no input-to-output path.
  assign cfg_ready   = (state == ST_LOAD);
  assign lookup_ok   = in_valid && (state == ST_RUN);
  assign lookup_drop = in_valid && (state != ST_RUN);

  // State and write-address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_addr <= '0;
    end else begin
      state   <= state_next;
      wr_addr <= wr_addr_next;
    end
  end

  // Next-state, address counter and write strobes.
  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    cfg_write    = 1'b0;
    last_write   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next   = ST_LOAD;
          wr_addr_next = '0;
        end
      end
      ST_LOAD: begin
        // cfg_start is ignored here: a load runs to completion or until rst.
        if (cfg_valid) begin
          cfg_write    = 1'b1;
          wr_addr_next = wr_addr + IN_BITS'(1);
          if (&wr_addr) begin
            last_write = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A lookup in this same cycle is still served from the old table.
        if (cfg_start) begin
          state_next   = ST_LOAD;
          wr_addr_next = '0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        wr_addr_next = '0;
      end
    endcase
  end

  // Status flags and the valid/drop pipeline that tracks the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_done  <= 1'b0;
      loaded    <= 1'b0;
      out_valid <= 1'b0;
      in_drop   <= 1'b0;
    end else begin
      cfg_done  <= last_write;
      out_valid <= lookup_ok;
      in_drop   <= lookup_drop;
      if (last_write) begin
        loaded <= 1'b1;
      end else if ((state == ST_RUN) && cfg_start) begin
        loaded <= 1'b0;
      end
    end
  end

  lut_table_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_write),
    .wr_addr (wr_addr),
    .wr_data (cfg_data),
    .rd_en   (lookup_ok),
    .rd_addr (in_data),
    .rd_data (out_data)
  );

endmodule
`default_nettype wire
